// File: rtl/pa_risc_pkg.sv
// Shared PA-RISC pipeline definitions: the NOP encoding, the PC increment,
// the fetch FSM state encoding and the major opcodes that decode also uses.
package pa_risc_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

  // Major opcode field: the 6 most significant bits of the instruction word
  localparam logic [5:0] OP_BL    = 6'b111010;
  localparam logic [5:0] OP_COMBT = 6'b100000;
  localparam logic [5:0] OP_COMBF = 6'b100010;

  function automatic logic [5:0] major_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch controls, the instruction ROM port,
// the PC pair and the IF/ID latch outputs.
interface fetch_stage_if #(
  parameter int PC_W    = 32,
  parameter int IMEM_AW = 9
);
  logic               le;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               nullify;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [PC_W-1:0]    pc_front;
  logic [PC_W-1:0]    pc_back;
  logic [31:0]        id_instr;
  logic [PC_W-1:0]    id_pc;
  logic               id_valid;
  logic               branch_pending;

  modport master (
    input  le, branch_taken, branch_target, nullify, imem_data,
    output imem_addr, pc_front, pc_back, id_instr, id_pc, id_valid, branch_pending
  );

  modport slave (
    output le, branch_taken, branch_target, nullify, imem_data,
    input  imem_addr, pc_front, pc_back, id_instr, id_pc, id_valid, branch_pending
  );
endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline latch: captures the fetched word and its PC on advance,
// substituting a NOP and clearing valid when the slot is nullified.
module if_id_register
  import pa_risc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            le,
  input  logic            nullify,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic            id_valid
);

  logic [31:0]     instr_reg;
  logic [PC_W-1:0] pc_reg;
  logic            valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (le) begin
      instr_reg <= nullify ? NOP_INSTR : instr;
      pc_reg    <= pc;
      valid_reg <= ~nullify;
    end
  end

  assign id_instr = instr_reg;
  assign id_pc    = pc_reg;
  assign id_valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// PA-RISC instruction fetch: PCFront/PCBack pair with one delay slot,
// a pending-branch FSM that holds a target resolved during a stall.
module fetch_stage
  import pa_risc_pkg::*;
#(
  parameter int          PC_W     = 32,
  parameter int          IMEM_AW  = 9,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                clk,
  input logic                reset,
  fetch_stage_if.master      bus
);

  localparam logic [PC_W-1:0] INC       = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] ALIGN     = ~PC_W'(3);
  localparam logic [PC_W-1:0] PC_FRONT0 = PC_W'(RESET_PC);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_front_reg, pc_back_reg, pc_back_next;
  logic [PC_W-1:0] pend_target_reg, pend_target_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      pend_target_reg <= '0;
      pc_front_reg    <= PC_FRONT0;
      pc_back_reg     <= PC_FRONT0 + INC;
    end else begin
      state_reg       <= state_next;
      pend_target_reg <= pend_target_next;
      if (bus.le) begin
        pc_front_reg <= pc_back_reg;
        pc_back_reg  <= pc_back_next;
      end
    end
  end

  // A branch resolved this cycle takes priority over one held from a stall
  always_comb begin
    state_next       = state_reg;
    pend_target_next = pend_target_reg;
    pc_back_next     = pc_back_reg + INC;
    if (bus.le) begin
      state_next = RUN;
      if (bus.branch_taken)
        pc_back_next = bus.branch_target & ALIGN;
      else if (state_reg == PEND)
        pc_back_next = pend_target_reg;
    end else if (bus.branch_taken) begin
      state_next       = PEND;
      pend_target_next = bus.branch_target & ALIGN;
    end
  end

  if_id_register #(.PC_W(PC_W)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .le       (bus.le),
    .nullify  (bus.nullify),
    .instr    (bus.imem_data),
    .pc       (pc_front_reg),
    .id_instr (bus.id_instr),
    .id_pc    (bus.id_pc),
    .id_valid (bus.id_valid)
  );

  assign bus.imem_addr      = pc_front_reg[IMEM_AW-1:0];
  assign bus.pc_front       = pc_front_reg;
  assign bus.pc_back        = pc_back_reg;
  assign bus.branch_pending = (state_reg == PEND);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, every cycle
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam int PC_W    = 32;
  localparam int IMEM_AW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(PC_W), .IMEM_AW(IMEM_AW)) bus ();

  fetch_stage #(.PC_W(PC_W), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [128];
  assign bus.imem_data = rom[bus.imem_addr[8:2]];

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_front, m_back, m_instr, m_pc, m_ptarget;
  logic        m_valid, m_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic le, input logic bt,
                            input logic [31:0] tgt, input logic nul);
    logic [31:0] nb;
    if (rst) begin
      m_front = 0; m_back = 4; m_instr = 0; m_pc = 0; m_valid = 0;
      m_pending = 0; m_ptarget = 0;
    end else if (le) begin
      if (bt)             nb = {tgt[31:2], 2'b00};
      else if (m_pending) nb = m_ptarget;
      else                nb = m_back + 32'd4;
      m_instr   = nul ? 32'h0 : rom[m_front[8:2]];
      m_valid   = !nul;
      m_pc      = m_front;
      m_front   = m_back;
      m_back    = nb;
      m_pending = 0;
    end else if (bt) begin
      m_pending = 1;
      m_ptarget = {tgt[31:2], 2'b00};
    end
  endtask

  // one clock: drive, edge, update model, sample 1 time unit later
  task automatic cycle(input logic rst, input logic le, input logic bt,
                       input logic [31:0] tgt, input logic nul);
    reset = rst; bus.le = le; bus.branch_taken = bt;
    bus.branch_target = tgt; bus.nullify = nul;
    @(posedge clk);
    model_step(rst, le, bt, tgt, nul);
    #1;
    $display("cyc rst=%0b le=%0b bt=%0b tgt=%h nul=%0b -> front=%h back=%h instr=%h valid=%0b pend=%0b",
             rst, le, bt, tgt, nul, bus.pc_front, bus.pc_back, bus.id_instr,
             bus.id_valid, bus.branch_pending);
    check("pc_front", bus.pc_front, m_front);
    check("pc_back", bus.pc_back, m_back);
    check("id_instr", bus.id_instr, m_instr);
    check("id_pc", bus.id_pc, m_pc);
    check("id_valid", 32'(bus.id_valid), 32'(m_valid));
    check("pending", 32'(bus.branch_pending), 32'(m_pending));
    check("imem_addr", 32'(bus.imem_addr), {23'h0, m_front[8:0]});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = i + 1;
    reset = 1; bus.le = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.nullify = 0;

    // reset and straight-line fetch
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("rst_front", bus.pc_front, 32'h0);
    check("rst_back", bus.pc_back, 32'h4);
    check("rst_valid", 32'(bus.id_valid), 32'h0);
    cycle(0, 1, 0, 0, 0);
    check("adv1_instr", bus.id_instr, 32'd1);
    check("adv1_valid", 32'(bus.id_valid), 32'h1);
    cycle(0, 1, 0, 0, 0);
    check("adv2_front", bus.pc_front, 32'h8);

    // stall hold, then resume
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    check("stall_front", bus.pc_front, 32'h8);
    check("stall_back", bus.pc_back, 32'hC);
    check("stall_instr", bus.id_instr, 32'd2);
    cycle(0, 1, 0, 0, 0);
    check("resume_front", bus.pc_front, 32'hC);

    // taken branch with delay slot
    cycle(0, 1, 1, 32'h40, 0);
    check("br_back", bus.pc_back, 32'h40);
    cycle(0, 1, 0, 0, 0);
    check("br_front", bus.pc_front, 32'h40);

    // branch captured during a stall
    cycle(0, 0, 1, 32'h80, 0);
    check("pend_set", 32'(bus.branch_pending), 32'h1);
    cycle(0, 1, 0, 0, 0);
    check("pend_apply", bus.pc_back, 32'h80);
    check("pend_clr", 32'(bus.branch_pending), 32'h0);

    // second branch while pending overwrites the held target
    cycle(0, 0, 1, 32'h100, 0);
    cycle(0, 0, 1, 32'h120, 0);
    cycle(0, 1, 0, 0, 0);
    check("pend_overwrite", bus.pc_back, 32'h120);

    // fresh branch beats a pending one
    cycle(0, 0, 1, 32'h200, 0);
    cycle(0, 1, 1, 32'h300, 0);
    check("fresh_wins", bus.pc_back, 32'h300);

    // nullify with and without advance
    cycle(0, 1, 0, 0, 1);
    check("null_instr", bus.id_instr, 32'h0);
    check("null_valid", 32'(bus.id_valid), 32'h0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("null_stall_valid", 32'(bus.id_valid), 32'h1);

    // wrap at top of address space, unaligned target masked
    cycle(0, 1, 1, 32'hFFFF_FFFF, 0);
    check("mask_back", bus.pc_back, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0, 0);
    check("wrap_back", bus.pc_back, 32'h0);
    check("alias_addr", 32'(bus.imem_addr), 32'h1FC);

    // reset while a branch is pending
    cycle(0, 0, 1, 32'h44, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_pend", 32'(bus.branch_pending), 32'h0);
    check("rst_pend_front", bus.pc_front, 32'h0);

    // random traffic
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      logic r, l, b, z;
      logic [31:0] t;
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 6) == 0);
      z = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      cycle(r, l, b, t, z);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
